// File: rtl/frame_sequencer_pkg.sv
// Shared APU frame-counter definitions: default step rate, $4017 field layout,
// sequencer mode and step encodings.
package frame_sequencer_pkg;

  localparam int unsigned STEP_HZ_DEFAULT = 240;

  // $4017 bit positions
  localparam int unsigned REG_MODE_BIT    = 7;
  localparam int unsigned REG_INHIBIT_BIT = 6;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } step_e;

  function automatic int unsigned round_div(input int unsigned num, input int unsigned den);
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/frame_sequencer_prescaler.sv
// Quarter-frame clock divider: counts 0..DIVISOR-1 and flags the terminal count.
module frame_prescaler #(
  parameter int unsigned DIVISOR = 7457
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] count;

  assign tc = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// APU frame counter: steps the 4/5-step sequence on each prescaler terminal count,
// drives the quarter/half-frame strobes and the frame IRQ flag, and decodes $4017 writes.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 1_789_773,
  parameter int unsigned STEP_HZ = STEP_HZ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_4017,
  input  logic       reg_event,
  input  logic       status_read,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq
);

  localparam int unsigned DIVISOR = round_div(CLK_HZ, STEP_HZ);

  logic  tc;
  mode_e mode_q;
  logic  inhibit_q;
  step_e step_q, step_d;
  logic  q240_d, q120_d, irq_set, irq_d;

  frame_prescaler #(.DIVISOR(DIVISOR)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (reg_event),
    .tc    (tc)
  );

  // A write restarts the sequence and swallows any coincident terminal count.
  always_comb begin
    step_d  = step_q;
    q240_d  = 1'b0;
    q120_d  = 1'b0;
    irq_set = 1'b0;
    if (reg_event) begin
      step_d = STEP0;
      q240_d = reg_4017[REG_MODE_BIT];
      q120_d = reg_4017[REG_MODE_BIT];
    end else if (tc) begin
      if (mode_q == MODE_5STEP) begin
        unique case (step_q)
          STEP0:   begin q240_d = 1'b1;                  step_d = STEP1; end
          STEP1:   begin q240_d = 1'b1; q120_d = 1'b1;   step_d = STEP2; end
          STEP2:   begin q240_d = 1'b1;                  step_d = STEP3; end
          STEP3:   begin                                 step_d = STEP4; end
          default: begin q240_d = 1'b1; q120_d = 1'b1;   step_d = STEP0; end
        endcase
      end else begin
        unique case (step_q)
          STEP0:   begin q240_d = 1'b1;                  step_d = STEP1; end
          STEP1:   begin q240_d = 1'b1; q120_d = 1'b1;   step_d = STEP2; end
          STEP2:   begin q240_d = 1'b1;                  step_d = STEP3; end
          default: begin
            q240_d  = 1'b1;
            q120_d  = 1'b1;
            irq_set = ~inhibit_q;
            step_d  = STEP0;
          end
        endcase
      end
    end

    irq_d = frame_irq;
    if (reg_event && reg_4017[REG_INHIBIT_BIT]) begin
      irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end else if (status_read) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_4STEP;
      inhibit_q    <= 1'b0;
      step_q       <= STEP0;
      enable_240hz <= 1'b0;
      enable_120hz <= 1'b0;
      frame_irq    <= 1'b0;
    end else begin
      if (reg_event) begin
        mode_q    <= mode_e'(reg_4017[REG_MODE_BIT]);
        inhibit_q <= reg_4017[REG_INHIBIT_BIT];
      end
      step_q       <= step_d;
      enable_240hz <= q240_d;
      enable_120hz <= q120_d;
      frame_irq    <= irq_d;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed scenarios plus random traffic
// compared every cycle against a cycle-count reference model.
module tb_frame_sequencer;

  localparam int unsigned DIV = 2400 / 240;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg_4017;
  logic       reg_event;
  logic       status_read;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  int   m_pcnt  = 0;
  int   m_tcs   = 0;
  logic m_mode  = 1'b0;
  logic m_inh   = 1'b0;
  logic m_irq   = 1'b0;
  logic m_240   = 1'b0;
  logic m_120   = 1'b0;

  always #5 clk = ~clk;

  frame_sequencer #(.CLK_HZ(2400)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_4017     (reg_4017),
    .reg_event    (reg_event),
    .status_read  (status_read),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // Predict outputs for the next cycle from this cycle's inputs.
  task automatic model_step(input logic r, input logic ev, input logic [7:0] d, input logic sr);
    int   s;
    logic set;
    m_240 = 1'b0;
    m_120 = 1'b0;
    set   = 1'b0;
    if (r) begin
      m_pcnt = 0; m_tcs = 0; m_mode = 1'b0; m_inh = 1'b0; m_irq = 1'b0;
    end else if (ev) begin
      m_mode = d[7];
      m_inh  = d[6];
      m_pcnt = 0;
      m_tcs  = 0;
      m_240  = d[7];
      m_120  = d[7];
      if (d[6]) m_irq = 1'b0;
      else if (sr) m_irq = 1'b0;
    end else begin
      if (m_pcnt == DIV - 1) begin
        s = m_tcs % (m_mode ? 5 : 4);
        m_tcs++;
        if (m_mode) begin
          m_240 = (s != 3);
          m_120 = (s == 1) || (s == 4);
        end else begin
          m_240 = 1'b1;
          m_120 = (s % 2 == 1);
          set   = (s == 3) && !m_inh;
        end
      end
      m_pcnt = (m_pcnt + 1) % DIV;
      if (set) m_irq = 1'b1;
      else if (sr) m_irq = 1'b0;
    end
  endtask

  task automatic run(input logic r, input logic ev, input logic [7:0] d, input logic sr);
    @(negedge clk);
    rst = r; reg_event = ev; reg_4017 = d; status_read = sr;
    model_step(r, ev, d, sr);
    @(posedge clk);
    #1;
    cyc = r ? 0 : cyc + 1;
    check("q240", enable_240hz, m_240);
    check("h120", enable_120hz, m_120);
    check("irq",  frame_irq,    m_irq);
  endtask

  task automatic idle();
    run(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    run(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_q240", enable_240hz, 1'b0);
    check("rst_irq",  frame_irq,    1'b0);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) idle();
  endtask

  // Free-running 4-step pattern straight out of reset.
  task automatic check_free_run();
    for (int i = 1; i <= 55; i++) begin
      idle();
      check("fr_q240", enable_240hz, (cyc % 10) == 0);
      check("fr_h120", enable_120hz, (cyc % 20) == 0);
      check("fr_irq",  frame_irq,    cyc >= 40);
    end
  endtask

  initial begin
    rst = 1'b1; reg_event = 1'b0; reg_4017 = 8'h00; status_read = 1'b0;

    // 1: free-run 4-step
    do_reset();
    check_free_run();

    // 2: 5-step write at cycle k=5
    do_reset();
    run_to(5);
    run(1'b0, 1'b1, 8'h80, 1'b0);
    check("s2_imm_q", enable_240hz, 1'b1);
    check("s2_imm_h", enable_120hz, 1'b1);
    for (int i = 2; i <= 100; i++) begin
      idle();
      if (i == 41) check("s2_no41", enable_240hz, 1'b0);
      if (i == 51) check("s2_h51",  enable_120hz, 1'b1);
      check("s2_irq", frame_irq, 1'b0);
    end

    // 3: IRQ clearing
    do_reset();
    run_to(41);
    run(1'b0, 1'b0, 8'h00, 1'b1);
    check("s3_sr_clr", frame_irq, 1'b0);
    run_to(85);
    check("s3_reset", frame_irq, 1'b1);
    run(1'b0, 1'b1, 8'h40, 1'b0);
    check("s3_inh_clr", frame_irq, 1'b0);
    while (cyc < 200) begin
      idle();
      check("s3_inh_hold", frame_irq, 1'b0);
    end
    run(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 45; i++) idle();
    check("s3_set_again", frame_irq, 1'b1);
    run(1'b0, 1'b1, 8'h00, 1'b0);
    check("s3_keep", frame_irq, 1'b1);

    // 4: write coincident with TC
    do_reset();
    run_to(9);
    run(1'b0, 1'b1, 8'h00, 1'b0);
    check("s4_no10", enable_240hz, 1'b0);
    while (cyc < 20) begin
      idle();
      check("s4_q240", enable_240hz, cyc == 20);
    end

    // 5: reset mid-sequence with IRQ pending
    do_reset();
    run_to(75);
    check("s5_irq_pre", frame_irq, 1'b1);
    do_reset();
    check("s5_h120", enable_120hz, 1'b0);
    check_free_run();

    // 6: status_read coincident with the IRQ-setting TC
    do_reset();
    run_to(39);
    run(1'b0, 1'b0, 8'h00, 1'b1);
    check("s6_set_wins", frame_irq, 1'b1);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run($urandom_range(0, 499) == 0,
          $urandom_range(0, 59) == 0,
          8'($urandom),
          $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
